// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the MEM stage.
// Each access stalls the pipeline for WAIT_CYCLES cycles, then respValid
// pulses for one cycle with readData already registered.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flags and suppresses
// accesses whose byte address is not word aligned).
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        respValid,
  output logic        memStall,
  output logic        alignErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        wr_q;
  logic [31:0] readData_q, readData_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          accept;
  logic          stall_c;
  logic          fire;
  logic          acc_wr;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_data;
  logic          acc_mis;
  logic [AW-1:0] idx;
  logic          unused_bits;

  assign req    = memRead | memWrite;
  assign accept = (state_q == IDLE) && req;

  // With a single wait cycle the access completes at the end of the accept
  // cycle, before the latched copies exist, so the live inputs are used then.
  assign acc_wr   = (state_q == IDLE) ? memWrite  : wr_q;
  assign acc_addr = (state_q == IDLE) ? address   : addr_q;
  assign acc_data = (state_q == IDLE) ? writeData : wdata_q;
  assign idx      = acc_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_mis  = |acc_addr[1:0];
  assign alignErr = (state_q == DONE) && (|addr_q[1:0]);
`else
  assign acc_mis  = 1'b0;
  assign alignErr = 1'b0;
`endif

  // Upper address bits wrap and, without the alignment check, byte offset is ignored.
  assign unused_bits = ^{acc_addr[31:AW+2], acc_addr[1:0], addr_q[1:0]};

  // Next-state, wait counter, stall and completion-edge decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          if (WAIT_CYCLES > 1) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            fire    = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      DONE: begin
        // Request still held by the stage this cycle belongs to the finished access.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load data path: only a completing read updates readData.
  always_comb begin
    readData_d = readData_q;
    if (fire && !acc_wr) begin
      readData_d = acc_mis ? 32'h0 : mem[idx];
    end
  end

  // Control state and readData, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readData_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readData_q <= readData_d;
    end
  end

  // Capture the request so later input changes during the stall are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address;
      wdata_q <= writeData;
      wr_q    <= memWrite;
    end
  end

  // Array write on the completing edge; reset aborts it and never clears contents.
  always_ff @(posedge clk) begin
    if (fire && acc_wr && !acc_mis && !rst) begin
      mem[idx] <= acc_data;
    end
  end

  assign readData  = readData_q;
  assign respValid = (state_q == DONE);
  assign memStall  = stall_c & ~rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with
// WAIT_CYCLES = 1, 2, 3 share clock and reset; a vector table drives the
// W=2 instance, hand-written sequences cover back-to-back, reset abort and
// misalignment. Completions are checked against a scoreboard queue.
module tb_dmem_responder;

  logic             clk;
  logic             rst;
  logic [2:0]       rd_s, wr_s;
  logic [2:0][31:0] ad_s, wd_s;
  logic [2:0][31:0] rdata;
  logic [2:0]       resp, stall, aerr;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(g + 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .memRead  (rd_s[g]),
      .memWrite (wr_s[g]),
      .address  (ad_s[g]),
      .writeData(wd_s[g]),
      .readData (rdata[g]),
      .respValid(resp[g]),
      .memStall (stall[g]),
      .alignErr (aerr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [31:0] d;
    logic        al;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        idle_after;
  } vec_t;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Completion monitor: every respValid must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (resp[k] === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'(k), 32'hFFFF_FFFF);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check("resp_inst", 32'(k), 32'(e.k));
            check("resp_rdata", rdata[k], e.d);
            check("resp_alignErr", {31'b0, aerr[k]}, {31'b0, e.al});
          end
        end
      end
    end
  end

  // Drives one access on instance k (WAIT_CYCLES = k+1) starting now,
  // scrambling address/data while stalled, and checks stall timing.
  task automatic do_access(input int k, input logic wr, input logic rd,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input logic al,
                           input logic idle_after);
    int w;
    sb_t e;
    w = k + 1;
    rd_s[k] = rd; wr_s[k] = wr; ad_s[k] = a; wd_s[k] = d;
    e.k = k; e.d = exp; e.al = al;
    sb.push_back(e);
    for (int c = 0; c < w; c++) begin
      @(negedge clk);
      check("stall_high", {31'b0, stall[k]}, 32'd1);
      check("resp_early", {31'b0, resp[k]}, 32'd0);
      @(posedge clk); #1;
      if (c < w - 1) begin
        ad_s[k] = a ^ 32'h5A5A_0FF0;
        wd_s[k] = ~d;
      end
    end
    ad_s[k] = a; wd_s[k] = d;
    @(negedge clk);
    check("stall_done", {31'b0, stall[k]}, 32'd0);
    check("resp_done", {31'b0, resp[k]}, 32'd1);
    @(posedge clk); #1;
    if (idle_after) begin
      rd_s[k] = 1'b0; wr_s[k] = 1'b0;
      @(negedge clk);
      check("stall_idle", {31'b0, stall[k]}, 32'd0);
      check("resp_idle", {31'b0, resp[k]}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    logic mis_al;
    logic [31:0] mis_exp;

    vt[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0014, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0BAD_C0DE, 32'hA5A5_A5A5, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_C0DE, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h1111_2222, 32'h0BAD_C0DE, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1111_2222, 1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h0000_0004, 32'h4444_4444, 32'h1111_2222, 1'b0};
    vt[11] = '{1'b0, 1'b1, 32'h0000_0404, 32'h0000_0000, 32'h4444_4444, 1'b1};

    rst = 1'b1;
    rd_s = '0; wr_s = '0; ad_s = '0; wd_s = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_rdata", rdata[k], 32'h0);
      check("rst_stall", {31'b0, stall[k]}, 32'd0);
      check("rst_resp", {31'b0, resp[k]}, 32'd0);
      check("rst_alignErr", {31'b0, aerr[k]}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven accesses on the W=2 instance, first one right after reset.
    for (int i = 0; i < 12; i++) begin
      do_access(1, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data,
                vt[i].exp_rd, 1'b0, vt[i].idle_after);
    end

    // Misaligned read of 0x6 on W=2.
`ifdef DMEM_ALIGN_CHECK_EN
    mis_al = 1'b1; mis_exp = 32'h0;
`else
    mis_al = 1'b0; mis_exp = 32'h4444_4444;
`endif
    do_access(1, 1'b0, 1'b1, 32'h0000_0006, 32'h0, mis_exp, mis_al, 1'b1);

    // W=1: two writes, then two reads requested continuously (stall 1,0,1,0).
    do_access(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0A0A_0A0A, 32'h0, 1'b0, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0B0B_0B0B, 32'h0, 1'b0, 1'b0);
    do_access(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'h0A0A_0A0A, 1'b0, 1'b0);
    do_access(0, 1'b0, 1'b1, 32'h0000_0004, 32'h0, 32'h0B0B_0B0B, 1'b0, 1'b1);

    // W=3: establish old contents at 0x20, then abort a write with reset.
    do_access(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_5555, 32'h0, 1'b0, 1'b1);
    rd_s[2] = 1'b0; wr_s[2] = 1'b1; ad_s[2] = 32'h20; wd_s[2] = 32'h1234;
    @(negedge clk);
    check("abort_stall_c0", {31'b0, stall[2]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; wr_s[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_stall", {31'b0, stall[2]}, 32'd0);
      check("abort_resp", {31'b0, resp[2]}, 32'd0);
      @(posedge clk); #1;
    end
    check("abort_rdata_rst", rdata[2], 32'h0);
    check("other_rdata_rst", rdata[1], 32'h0);
    do_access(2, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h0000_5555, 1'b0, 1'b1);
    // Array contents survive reset on another instance too.
    do_access(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL use parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the array; legal values are powers of two from 16 to 4096.
REQ-002 The block SHALL use parameter WAIT_CYCLES, default 2, meaning the number of stall cycles per access; legal values are 1 to 15.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port memRead, input, width 1: read request from the MEM stage.
REQ-006 The block SHALL have port memWrite, input, width 1: write request from the MEM stage.
REQ-007 The block SHALL have port address, input, width 32: byte address, which is the ALU result.
REQ-008 The block SHALL have port writeData, input, width 32: store data.
REQ-009 The block SHALL have port readData, output, width 32: registered load data.
REQ-010 The block SHALL have port respValid, output, width 1: one-cycle completion pulse.
REQ-011 The block SHALL have port memStall, output, width 1: freezes the pipeline while an access is pending.
REQ-012 The block SHALL have port alignErr, output, width 1: misaligned-access flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 A request is memRead or memWrite high; if both are high, the access SHALL be treated as a write.
REQ-015 In IDLE with a request in cycle 0, the block SHALL:
  - drive memStall high combinationally in cycle 0;
  - latch address, writeData and the access type at the end of cycle 0;
  - load the 4-bit wait counter with WAIT_CYCLES-1;
  - go to BUSY if WAIT_CYCLES>1, otherwise to DONE.
REQ-016 In BUSY the block SHALL hold memStall high and decrement the counter each cycle; on the cycle the counter equals 1 it goes to DONE.
REQ-017 memStall SHALL be high for exactly WAIT_CYCLES consecutive cycles (0 to W-1) and low in cycle W.
REQ-018 For a write, the array SHALL be updated at the word index latchedAddr[log2(DEPTH_WORDS)+1:2] on the clock edge ending cycle W-1.
REQ-019 For a read, readData SHALL be loaded from that word index on the clock edge ending cycle W-1, so it is valid in cycle W.
REQ-020 In DONE (cycle W), respValid SHALL be high and memStall low; the state returns to IDLE at the end of cycle W.
REQ-021 Request inputs present in cycle W SHALL be ignored, because they are the completed access still held by the stage.
REQ-022 A new request SHALL be accepted no earlier than cycle W+1, which allows back-to-back accesses with one idle-free turnaround cycle.
REQ-023 readData SHALL hold its last loaded value until the next read completes; writes SHALL NOT change readData.
REQ-024 Address bits above log2(DEPTH_WORDS)+1 SHALL be ignored, so addresses wrap modulo the array size.
REQ-025 Request inputs changing during BUSY SHALL have no effect, because the latched copies are used.
REQ-026 With no request in IDLE, memStall and respValid SHALL be 0 and the array is unchanged.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL:
  - set the state to IDLE;
  - set the counter to 0;
  - set readData to 32'h0;
  - set respValid, memStall and alignErr to 0.
REQ-028 Reset asserted mid-access SHALL abort the access; a pending write SHALL NOT reach the array, and no respValid is produced.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 A request present in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-031 When macro DMEM_ALIGN_CHECK_EN is defined, an access with latched address[1:0] != 2'b00 SHALL:
  - follow the normal WAIT_CYCLES stall timing;
  - not write the array;
  - load readData with 32'h0 for reads;
  - pulse alignErr high in cycle W together with respValid.
REQ-032 When DMEM_ALIGN_CHECK_EN is not defined, address[1:0] SHALL be ignored and alignErr SHALL be tied to 0.

Verification
REQ-033 Write then read, W=2:
  - stimulus: write address 32'h10, data 32'hDEADBEEF, then read address 32'h10;
  - response: for each access, memStall is high for 2 cycles, then respValid pulses; after the read, readData = 32'hDEADBEEF.
REQ-034 Back-to-back reads, W=1:
  - stimulus: reads of addresses 32'h0 and 32'h4, requested continuously;
  - response: memStall is 1,0,1,0 across cycles 0-3; respValid pulses in cycles 1 and 3 with the correct word each time.
REQ-035 Reset mid-write, W=3:
  - stimulus: write address 32'h20 with 32'h1234; assert rst in cycle 1;
  - response: memStall is 0 after reset, no respValid, and a later read of 32'h20 returns the old contents.
REQ-036 Simultaneous memRead and memWrite:
  - stimulus: both high, address 32'h8, data 32'hA5A5A5A5;
  - response: the write is performed, readData is unchanged, and a later read of 32'h8 returns 32'hA5A5A5A5.
REQ-037 Address wrap, DEPTH_WORDS=256:
  - stimulus: write to address 32'h400;
  - response: a read of address 32'h0 returns the written data.
REQ-038 Misaligned access with DMEM_ALIGN_CHECK_EN defined:
  - stimulus: read address 32'h6;
  - response: alignErr and respValid pulse together in cycle W, and readData = 32'h0.
